// File: rtl/rr_arb2_stream_if.sv
// Stream bundle for the two-input round-robin arbiter: two source
// channels, one registered output channel, and the mux select / busy status.
interface rr_arb2_stream_if #(
  parameter int W = 8
);
  logic         in0_valid;
  logic [W-1:0] in0_data;
  logic         in0_last;
  logic         in0_ready;

  logic         in1_valid;
  logic [W-1:0] in1_data;
  logic         in1_last;
  logic         in1_ready;

  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  logic         sel;
  logic         busy;

  // Environment side: drives the sources and the downstream ready
  modport master (
    output in0_valid, in0_data, in0_last,
    input  in0_ready,
    output in1_valid, in1_data, in1_last,
    input  in1_ready,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  sel, busy
  );

  // Arbiter side
  modport slave (
    input  in0_valid, in0_data, in0_last,
    output in0_ready,
    input  in1_valid, in1_data, in1_last,
    output in1_ready,
    output out_valid, out_data, out_last,
    input  out_ready,
    output sel, busy
  );
endinterface

// File: rtl/rr_arb2_stream.sv
// Two-input round-robin stream arbiter with a one-entry registered output
// stage. The grant is held for a whole packet when PKT_LOCK is set, so
// packets from the two sources never interleave. sel feeds the downstream
// 2:1 mux and only changes when a new grant is issued from IDLE.
module rr_arb2_stream #(
  parameter int W        = 8,
  parameter bit PKT_LOCK = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  rr_arb2_stream_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t       state;
  logic         ptr;
  logic         sel_q;
  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic         out_last_q;

  logic         out_free;
  logic         rdy0;
  logic         rdy1;
  logic         acc0;
  logic         acc1;

  // Ready only for the granted source, and only when the output slot is
  // empty or draining this cycle; an accepted beat is valid && ready.
  always_comb begin
    out_free = !out_valid_q || bus.out_ready;
    rdy0     = (state == GRANT0) && out_free;
    rdy1     = (state == GRANT1) && out_free;
    acc0     = bus.in0_valid && rdy0;
    acc1     = bus.in1_valid && rdy1;
  end

  assign bus.in0_ready = rdy0;
  assign bus.in1_ready = rdy1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state != IDLE) || out_valid_q;

  // Grant FSM, round-robin pointer and output register, all in one process.
  // The pointer flips to the other source on every grant so that a
  // contended IDLE cycle always favours whoever was served less recently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (acc0) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in0_data;
        out_last_q  <= bus.in0_last;
      end else if (acc1) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in1_data;
        out_last_q  <= bus.in1_last;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.in0_valid && (!bus.in1_valid || !ptr)) begin
            state <= GRANT0;
            sel_q <= 1'b0;
            ptr   <= 1'b1;
          end else if (bus.in1_valid) begin
            state <= GRANT1;
            sel_q <= 1'b1;
            ptr   <= 1'b0;
          end
        end
        GRANT0: begin
          if (acc0 && (!PKT_LOCK || bus.in0_last)) begin
            state <= IDLE;
          end
        end
        GRANT1: begin
          if (acc1 && (!PKT_LOCK || bus.in1_last)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
